// File: rtl/led_frame_fetch_ctrl.sv
// led_frame_fetch_ctrl
// Read-side sequencer for the backlight zone FIFO. Each accepted frame_start
// pulls exactly ZONE_NUM words from a show-ahead FIFO and hands them to the
// serializer over valid/ready with a zone index and last flag. A starved FIFO
// is bounded by a timeout, after which the rest of the frame is padded.
module led_frame_fetch_ctrl #(
  parameter int                    DATA_WIDTH = 24,
  parameter int                    ZONE_NUM   = 256,
  parameter int                    ZONE_CNT_W = 8,
  parameter int                    TIMEOUT    = 4096,
  parameter int                    TO_W       = 13,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = 24'hFFFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  output logic                  fifo_rd_en,
  input  logic                  fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ZONE_CNT_W-1:0] out_zone,
  output logic                  out_last,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_overrun,
  output logic                  underrun_err
);

  // req_cnt is one bit wider than the zone index so ZONE_NUM = 2^ZONE_CNT_W fits
  localparam logic [ZONE_CNT_W:0] ZONE_NUM_C = (ZONE_CNT_W+1)'(ZONE_NUM);
  localparam logic [ZONE_CNT_W:0] LAST_IDX_C = (ZONE_CNT_W+1)'(ZONE_NUM - 1);
  localparam logic [ZONE_CNT_W:0] REQ_ONE    = (ZONE_CNT_W+1)'(1);
  localparam logic [TO_W-1:0]     TO_LIMIT   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]     TO_ONE     = TO_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PAD   = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [ZONE_CNT_W:0]     req_cnt_reg;
  logic [TO_W-1:0]         to_cnt_reg;
  logic                    out_vld_reg;
  logic [DATA_WIDTH-1:0]   out_data_reg;
  logic [ZONE_CNT_W-1:0]   out_zone_reg;
  logic                    out_last_reg;
  logic                    frame_done_reg;
  logic                    frame_overrun_reg;
  logic                    underrun_reg;

  logic                    can_load;
  logic                    accept;
  logic                    last_accept;
  logic                    more;
  logic                    rd_en;
  logic                    load_fifo;
  logic                    load_fill;
  logic                    load;
  logic                    starved;
  logic                    timeout_hit;
  logic                    start;
  logic                    overrun;
  logic [DATA_WIDTH-1:0]   load_word;

  // The single output register can take a new word when empty or draining
  assign can_load    = !out_vld_reg || out_rdy;
  assign accept      = out_vld_reg && out_rdy;
  assign last_accept = accept && out_last_reg;
  assign more        = req_cnt_reg < ZONE_NUM_C;
  assign load        = load_fifo || load_fill;
  assign load_word   = load_fifo ? fifo_rd_data : FILL_VALUE;
  assign overrun     = frame_start && (state_reg != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and per-cycle control; rd_en never looks at fifo_rd_vld
  always_comb begin
    state_next  = state_reg;
    rd_en       = 1'b0;
    load_fifo   = 1'b0;
    load_fill   = 1'b0;
    starved     = 1'b0;
    timeout_hit = 1'b0;
    start       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (frame_start) begin
          start      = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        rd_en     = can_load && more;
        load_fifo = rd_en && fifo_rd_vld;
        starved   = rd_en && !fifo_rd_vld;
        if (starved && (to_cnt_reg == TO_LIMIT)) begin
          timeout_hit = 1'b1;
          state_next  = PAD;
        end
        if (last_accept) state_next = IDLE;
      end
      PAD: begin
        load_fill = can_load && more;
        if (last_accept) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request and starvation counters, plus the frame-sticky underrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_cnt_reg  <= '0;
      to_cnt_reg   <= '0;
      underrun_reg <= 1'b0;
    end else if (start) begin
      req_cnt_reg  <= '0;
      to_cnt_reg   <= '0;
      underrun_reg <= 1'b0;
    end else begin
      if (load)           req_cnt_reg  <= req_cnt_reg + REQ_ONE;
      if (load_fifo)      to_cnt_reg   <= '0;
      else if (starved)   to_cnt_reg   <= to_cnt_reg + TO_ONE;
      if (timeout_hit)    underrun_reg <= 1'b1;
    end
  end

  // Output register: load on pop or pad, otherwise drop valid once accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_reg  <= 1'b0;
      out_data_reg <= '0;
      out_zone_reg <= '0;
      out_last_reg <= 1'b0;
    end else if (load) begin
      out_vld_reg  <= 1'b1;
      out_data_reg <= load_word;
      out_zone_reg <= req_cnt_reg[ZONE_CNT_W-1:0];
      out_last_reg <= (req_cnt_reg == LAST_IDX_C);
    end else if (accept) begin
      out_vld_reg  <= 1'b0;
    end
  end

  // One-cycle status pulses, registered so they follow the triggering cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done_reg    <= 1'b0;
      frame_overrun_reg <= 1'b0;
    end else begin
      frame_done_reg    <= last_accept;
      frame_overrun_reg <= overrun;
    end
  end

  assign fifo_rd_en    = rd_en;
  assign out_vld       = out_vld_reg;
  assign out_data      = out_data_reg;
  assign out_zone      = out_zone_reg;
  assign out_last      = out_last_reg;
  assign busy          = (state_reg != IDLE);
  assign frame_done    = frame_done_reg;
  assign frame_overrun = frame_overrun_reg;
  assign underrun_err  = underrun_reg;

endmodule

// File: tb/tb_led_frame_fetch_ctrl.sv
// tb_led_frame_fetch_ctrl
// Randomised frames against a queue-based FIFO model and an expected-word
// scoreboard. Stimulus pushes expected words per frame; a negedge monitor
// pops them on every output acceptance and checks pulses, busy and stalls.
module tb_led_frame_fetch_ctrl;

  localparam int DW  = 24;
  localparam int ZN  = 4;
  localparam int ZW  = 2;
  localparam int TMO = 8;
  localparam int TW  = 4;
  localparam logic [DW-1:0] FILL = 24'hFFFFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          fifo_rd_en;
  logic          fifo_rd_vld = 1'b0;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          out_vld;
  logic          out_rdy = 1'b0;
  logic [DW-1:0] out_data;
  logic [ZW-1:0] out_zone;
  logic          out_last;
  logic          busy;
  logic          frame_done;
  logic          frame_overrun;
  logic          underrun_err;

  led_frame_fetch_ctrl #(
    .DATA_WIDTH (DW),
    .ZONE_NUM   (ZN),
    .ZONE_CNT_W (ZW),
    .TIMEOUT    (TMO),
    .TO_W       (TW),
    .FILL_VALUE (FILL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_vld   (fifo_rd_vld),
    .fifo_rd_data  (fifo_rd_data),
    .out_vld       (out_vld),
    .out_rdy       (out_rdy),
    .out_data      (out_data),
    .out_zone      (out_zone),
    .out_last      (out_last),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_overrun (frame_overrun),
    .underrun_err  (underrun_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [ZW-1:0] zone;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] fifo_q[$];
  bit            under_q[$];

  int vectors     = 0;
  int miscompares = 0;

  // driver knobs
  int rdy_mode = 0;
  int rdy_pct  = 100;
  int gap_min  = 1;
  int gap_max  = 0;
  int gap_pct  = 0;
  int gap_left = 0;
  int cyc_n    = 0;
  int acc_total = 0;
  bit last_pop = 1'b0;

  // monitor model state
  bit   model_busy     = 1'b0;
  bit   exp_done       = 1'b0;
  bit   exp_ovr        = 1'b0;
  bit   exp_under_idle = 1'b0;
  bit   prev_stall     = 1'b0;
  exp_t prev_out;
  exp_t mon_e;
  bit   mon_acc;
  bit   mon_acc_last;
  bit   mon_ovr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: all checks and model updates happen on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      model_busy     = 1'b0;
      exp_done       = 1'b0;
      exp_ovr        = 1'b0;
      exp_under_idle = 1'b0;
      prev_stall     = 1'b0;
      last_pop       = 1'b0;
    end else begin
      mon_acc      = out_vld && out_rdy;
      mon_acc_last = 1'b0;
      chk("frame_done", 32'(frame_done), 32'(exp_done));
      chk("frame_overrun", 32'(frame_overrun), 32'(exp_ovr));
      chk("busy", 32'(busy), 32'(model_busy));
      if (!model_busy) chk("underrun_err_idle", 32'(underrun_err), 32'(exp_under_idle));
      if (out_vld && !out_rdy) chk("rd_en_while_stalled", 32'(fifo_rd_en), 32'd0);
      if (prev_stall) begin
        chk("stall_vld",  32'(out_vld),  32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_out.data));
        chk("stall_zone", 32'(out_zone), 32'(prev_out.zone));
        chk("stall_last", 32'(out_last), 32'(prev_out.last));
      end
      if (mon_acc) begin
        acc_total++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got zone %0d data %06h, expected no word", out_zone, out_data);
        end else begin
          mon_e = exp_q.pop_front();
          $display("word zone %0d data %06h last %0d", out_zone, out_data, out_last);
          chk("out_data", 32'(out_data), 32'(mon_e.data));
          chk("out_zone", 32'(out_zone), 32'(mon_e.zone));
          chk("out_last", 32'(out_last), 32'(mon_e.last));
          mon_acc_last = mon_e.last;
          if (mon_e.last) begin
            if (under_q.size() > 0) exp_under_idle = under_q.pop_front();
            chk("underrun_err_at_last", 32'(underrun_err), 32'(exp_under_idle));
          end
        end
      end
      if (fifo_rd_en && fifo_rd_vld) begin
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        last_pop = 1'b1;
      end else begin
        last_pop = 1'b0;
      end
      mon_ovr = frame_start && model_busy;
      if (frame_start && !model_busy) model_busy = 1'b1;
      if (mon_acc_last) model_busy = 1'b0;
      exp_done      = mon_acc_last;
      exp_ovr       = mon_ovr;
      prev_stall    = out_vld && !out_rdy;
      prev_out.data = out_data;
      prev_out.zone = out_zone;
      prev_out.last = out_last;
    end
  end

  // One clock: wait past the edge, then drive ready and the FIFO head
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    if (rdy_mode == 0)      out_rdy = 1'b1;
    else if (rdy_mode == 1) out_rdy = (cyc_n % 3 == 0);
    else                    out_rdy = ($urandom_range(0, 99) < rdy_pct);
    if (gap_left > 0) begin
      gap_left--;
      fifo_rd_vld = 1'b0;
    end else if (gap_max > 0 && last_pop && $urandom_range(0, 99) < gap_pct) begin
      gap_left    = $urandom_range(gap_min, gap_max) - 1;
      fifo_rd_vld = 1'b0;
    end else begin
      fifo_rd_vld = (fifo_q.size() > 0);
    end
    fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  // Queue k FIFO words and the expected frame, then run it to frame_done
  task automatic run_frame(input int k, input bit ovr_mid, input bit ovr_end);
    exp_t e;
    bit   seen;
    for (int i = 0; i < ZN; i++) begin
      e.zone = ZW'(i);
      e.last = (i == ZN - 1);
      if (i < k) begin
        e.data = DW'($urandom);
        fifo_q.push_back(e.data);
      end else begin
        e.data = FILL;
      end
      exp_q.push_back(e);
    end
    under_q.push_back(k < ZN);
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      cyc();
      frame_start = 1'b0;
      if (ovr_mid && n == 2) frame_start = 1'b1;
      if (ovr_end && out_vld && out_last) begin
        out_rdy     = 1'b1;
        frame_start = 1'b1;
      end
      if (frame_done) seen = 1'b1;
    end
    frame_start = 1'b0;
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_timeout: got no frame_done, expected one within 300 cycles");
    end
    repeat (2) cyc();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_vld"},       32'(out_vld),       32'd0);
    chk({tag, "_out_data"},      32'(out_data),      32'd0);
    chk({tag, "_out_zone"},      32'(out_zone),      32'd0);
    chk({tag, "_out_last"},      32'(out_last),      32'd0);
    chk({tag, "_busy"},          32'(busy),          32'd0);
    chk({tag, "_frame_done"},    32'(frame_done),    32'd0);
    chk({tag, "_frame_overrun"}, 32'(frame_overrun), 32'd0);
    chk({tag, "_underrun_err"},  32'(underrun_err),  32'd0);
    chk({tag, "_fifo_rd_en"},    32'(fifo_rd_en),    32'd0);
  endtask

  initial begin
    exp_t e;
    int   base;
    int   k;
    #3;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();

    // nominal frame, ready held high
    rdy_mode = 0; gap_max = 0;
    run_frame(4, 1'b0, 1'b0);
    // backpressure pattern 1,0,0,...
    rdy_mode = 1;
    run_frame(4, 1'b0, 1'b0);
    run_frame(4, 1'b0, 1'b0);
    // underrun: only 2 of 4 words available
    rdy_mode = 0;
    run_frame(2, 1'b0, 1'b0);
    rdy_mode = 1;
    run_frame(1, 1'b0, 1'b0);
    // overrun mid-frame and coincident with the last acceptance
    rdy_mode = 0;
    run_frame(4, 1'b1, 1'b1);
    // 5-cycle FIFO gaps after every pop stay below the timeout
    gap_min = 5; gap_max = 5; gap_pct = 100;
    run_frame(4, 1'b0, 1'b0);
    rdy_mode = 2; rdy_pct = 60;
    run_frame(4, 1'b0, 1'b0);

    // reset mid-frame after zone 1 is accepted
    rdy_mode = 0; gap_max = 0;
    for (int i = 0; i < ZN; i++) begin
      e.zone = ZW'(i);
      e.last = (i == ZN - 1);
      e.data = DW'($urandom);
      fifo_q.push_back(e.data);
      exp_q.push_back(e);
    end
    under_q.push_back(1'b0);
    base = acc_total;
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    for (int n = 0; n < 50 && acc_total < base + 2; n++) cyc();
    chk("reset_setup_accepts", 32'(acc_total - base), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("midreset");
    cyc();
    cyc();
    fifo_q.delete();
    exp_q.delete();
    under_q.delete();
    gap_left    = 0;
    fifo_rd_vld = 1'b0;
    rst = 1'b0;
    cyc();
    run_frame(4, 1'b0, 1'b0);

    // randomised frames
    repeat (30) begin
      rdy_mode = 2;
      rdy_pct  = ($urandom_range(0, 2) == 0) ? 100 : $urandom_range(25, 90);
      gap_min  = 1;
      gap_max  = $urandom_range(0, 5);
      gap_pct  = 30;
      k = ($urandom_range(0, 4) == 0) ? $urandom_range(0, ZN - 1) : ZN;
      run_frame(k, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    repeat (3) cyc();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_frame_fetch_ctrl.md
Name: led_frame_fetch_ctrl

Overview:
- Read-side sequencer for the LED backlight zone FIFO (24-bit, show-ahead, rd_en/rd_vld handshake).
- On each frame_start it pulls exactly ZONE_NUM zone words from the FIFO and presents them downstream with a zone index and a last flag over a valid/ready interface.
- Sits between the dimming-value FIFO and the LED driver serializer.
- A FIFO underrun is bounded by a timeout; missing zones are padded with a safe fill value so every frame always delivers ZONE_NUM words.

Parameters:
- DATA_WIDTH, 24, zone word width; matches the FIFO read width.
- ZONE_NUM, 256, zone words per frame; legal range 2..(2^ZONE_CNT_W).
- ZONE_CNT_W, 8, width of the zone index.
- TIMEOUT, 4096, consecutive starved cycles before underrun; legal range 1..(2^TO_W-1).
- TO_W, 13, width of the timeout counter.
- FILL_VALUE, 24'hFFFFFF, pad word emitted after an underrun.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse that starts a frame fetch.
- fifo_rd_en  out  1  pop request to the FIFO.
- fifo_rd_vld  in  1  FIFO head valid.
- fifo_rd_data  in  DATA_WIDTH  FIFO head data.
- out_vld  out  1  output word valid.
- out_rdy  in  1  downstream ready.
- out_data  out  DATA_WIDTH  zone word.
- out_zone  out  ZONE_CNT_W  zone index, 0..ZONE_NUM-1.
- out_last  out  1  high with zone ZONE_NUM-1.
- busy  out  1  high when state is not IDLE.
- frame_done  out  1  one-cycle pulse when the last word is accepted.
- frame_overrun  out  1  one-cycle pulse when frame_start is ignored.
- underrun_err  out  1  sticky underrun flag for the current frame.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- Transfer definitions:
  - FIFO pop: a cycle with fifo_rd_en and fifo_rd_vld both high.
  - Output accept: a cycle with out_vld and out_rdy both high.
- Single output register. can_load = !out_vld || out_rdy.
- States and transitions:
  - IDLE: on frame_start go to FETCH; clear underrun_err, req_cnt and timeout counter.
  - FETCH:
    - fifo_rd_en = can_load && (req_cnt < ZONE_NUM). Combinational; must not depend on fifo_rd_vld.
    - On a pop, the next cycle has out_vld=1, out_data=fifo_rd_data, out_zone=req_cnt, out_last=(req_cnt==ZONE_NUM-1), and req_cnt increments.
    - Load latency is 1 cycle from pop to out_vld.
    - Back-to-back: with out_rdy held high, one word per cycle.
    - Timeout counter increments on cycles with fifo_rd_en=1 and fifo_rd_vld=0. It clears on a pop. It holds while stalled (fifo_rd_en=0).
    - When the counter reaches TIMEOUT: set underrun_err, go to PAD, stop popping.
  - PAD:
    - fifo_rd_en=0.
    - When can_load and req_cnt < ZONE_NUM: load out_data=FILL_VALUE with the same zone/last rules, then req_cnt++.
  - From FETCH or PAD: on acceptance of the word with out_last=1, pulse frame_done, clear out_vld, go to IDLE.
- Output data stability: while out_vld && !out_rdy, out_data, out_zone and out_last hold.
- out_vld drops after an acceptance unless a new word loads in the same cycle.
- frame_start while busy: ignored, frame_overrun pulses 1 cycle, and the frame in progress is unaffected.
- frame_start in the same cycle as the frame_done acceptance: ignored with frame_overrun, because state is still non-IDLE that cycle.
- underrun_err stays set through IDLE until the next accepted frame_start.
- FIFO words that arrive after an underrun are not flushed; they belong to the next frame. This is intended: the upstream resynchronises on frame boundaries.
- Asynchronous reset mid-frame: immediate return to IDLE, outputs 0; a partial frame is abandoned.
- Counter widths: req_cnt is ZONE_CNT_W+1 bits so ZONE_NUM=2^ZONE_CNT_W is representable; out_zone takes its low bits.

Test Plan:
- Nominal frame (ZONE_NUM=4, FIFO holds 0x000010..0x000013, out_rdy=1, frame_start) -> 4 consecutive words, zones 0..3, out_last on zone 3, frame_done 1 cycle after the zone-3 acceptance, underrun_err=0.
- Backpressure (out_rdy toggling 1,0,0,1,...) -> no word lost or duplicated; out_data is stable while stalled; fifo_rd_en=0 whenever out_vld && !out_rdy.
- Underrun (TIMEOUT=8, FIFO holds only 2 words of 4) -> zones 0..1 carry FIFO data; after 8 starved cycles underrun_err=1; zones 2..3 = 0xFFFFFF with out_last on zone 3; frame_done pulses.
- Overrun: frame_start pulsed mid-frame and again coincident with the frame_done acceptance -> frame_overrun pulses twice, the frame completes normally, and no new frame starts.
- Reset mid-frame: rst asserted after zone 1 -> outputs 0 immediately, busy=0; a subsequent frame_start fetches zones starting from 0.
- FIFO gaps: fifo_rd_vld low for 5 cycles (TIMEOUT=8) between words -> no underrun; the timeout counter restarts after each pop.
